srio_nwr_target: RTL

Target-side NWRITE/NWRITE_R terminator sitting directly downstream of `db_req` on the SRIO logical layer. It consumes HELLO-format request packets from the ireq AXI4-Stream, unpacks header and payload, and streams the payload with an incrementing byte address to a user write port. For NWRITE_R it builds and returns a response packet on the iresp stream feeding `db_req`. Bench loopback and hardware target use the same block.

---
 rtl/srio_pkg.sv | 48 ++++
 rtl/srio_hello_hdr.sv | 37 +++
 rtl/srio_nwr_target.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/srio_pkg.sv
// Shared SRIO logical-layer definitions: HELLO header layout, FTYPE/TTYPE/status
// codes and the NWRITE target state encoding. Also used by db_req.
package srio_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned USER_W = 32;
  localparam int unsigned ADDR_W = 34;
  localparam int unsigned STAT_W = 16;

  localparam logic [3:0] FTYPE_WRITE       = 4'h5;
  localparam logic [3:0] FTYPE_RESP        = 4'hD;
  localparam logic [3:0] TTYPE_NWRITE      = 4'h4;
  localparam logic [3:0] TTYPE_NWRITE_R    = 4'h5;
  localparam logic [3:0] TTYPE_RESP_NODATA = 4'h0;
  localparam logic [3:0] STATUS_DONE       = 4'h0;
  localparam logic [3:0] STATUS_ERROR      = 4'h7;

  // HELLO header beat; for responses the size field carries {status, 4'h0}
  typedef struct packed {
    logic [7:0]        tid;
    logic [3:0]        ftype;
    logic [3:0]        ttype;
    logic              rsvd0;
    logic [1:0]        prio;
    logic              crf;
    logic [7:0]        size;
    logic [1:0]        rsvd1;
    logic [ADDR_W-1:0] addr;
  } hello_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_DROP,
    ST_RESP
  } nwr_state_e;

  // Response priority is one above the request, capped at 3
  function automatic logic [1:0] bump_prio(input logic [1:0] p);
    return (p == 2'd3) ? 2'd3 : p + 2'd1;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/srio_hello_hdr.sv
// Combinational HELLO header unpack (request decode) and pack (response encode).
// Ports: req_data -> req_hdr/req_legal; rsp_tid/req_prio/rsp_crf/rsp_status -> rsp_data.
module srio_hello_hdr
  import srio_pkg::*;
(
  input  logic [DATA_W-1:0] req_data,
  output hello_hdr_t        req_hdr,
  output logic              req_legal,
  input  logic [7:0]        rsp_tid,
  input  logic [1:0]        req_prio,
  input  logic              rsp_crf,
  input  logic [3:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data
);

  hello_hdr_t rsp;

  // Request decode: only NWRITE and NWRITE_R terminate here
  always_comb begin
    req_hdr   = hello_hdr_t'(req_data);
    req_legal = (req_hdr.ftype == FTYPE_WRITE) &&
                ((req_hdr.ttype == TTYPE_NWRITE) || (req_hdr.ttype == TTYPE_NWRITE_R));
  end

  // Response encode: every field not listed stays zero
  always_comb begin
    rsp       = '0;
    rsp.tid   = rsp_tid;
    rsp.ftype = FTYPE_RESP;
    rsp.ttype = TTYPE_RESP_NODATA;
    rsp.prio  = bump_prio(req_prio);
    rsp.crf   = rsp_crf;
    rsp.size  = {rsp_status, 4'h0};
    rsp_data  = DATA_W'(rsp);
  end

endmodule

// File: rtl/srio_nwr_target.sv
// NWRITE/NWRITE_R target: decodes HELLO request headers from treq, streams the
// payload with incrementing byte address to the wr port, and returns a response
// on tresp for NWRITE_R. pkt_cnt counts clean packets (wraps), err_cnt counts
// errored/dropped packets (saturates). The wr port is a combinational
// pass-through of treq while in DATA; the response is registered.
module srio_nwr_target
  import srio_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 32
) (
  input  logic              log_clk,
  input  logic              log_rst_n,
  input  logic              treq_tvalid,
  output logic              treq_tready,
  input  logic              treq_tlast,
  input  logic [DATA_W-1:0] treq_tdata,
  input  logic [KEEP_W-1:0] treq_tkeep,
  input  logic [USER_W-1:0] treq_tuser,
  output logic              tresp_tvalid,
  input  logic              tresp_tready,
  output logic              tresp_tlast,
  output logic [DATA_W-1:0] tresp_tdata,
  output logic [KEEP_W-1:0] tresp_tkeep,
  output logic [USER_W-1:0] tresp_tuser,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [KEEP_W-1:0] wr_keep,
  output logic              wr_first,
  output logic              wr_last,
  output logic [STAT_W-1:0] pkt_cnt,
  output logic [STAT_W-1:0] err_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  nwr_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, exp_q, exp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tid_q, tid_d;
  logic [1:0]        prio_q, prio_d;
  logic              crf_q, crf_d;
  logic              resp_q, resp_d;
  logic [USER_W-1:0] user_q, user_d;
  logic              over_q, over_d;
  logic              live_q;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic [USER_W-1:0] rsp_user_d;
  logic [STAT_W-1:0] pkt_cnt_d, err_cnt_d;

  hello_hdr_t        req_hdr;
  logic              req_legal;
  logic [3:0]        rsp_status;
  logic [DATA_W-1:0] rsp_enc;
  logic              fwd, hs, last_exp;
  logic              unused_req;

  srio_hello_hdr u_hdr (
    .req_data   (treq_tdata),
    .req_hdr    (req_hdr),
    .req_legal  (req_legal),
    .rsp_tid    (tid_q),
    .req_prio   (prio_q),
    .rsp_crf    (crf_q),
    .rsp_status (rsp_status),
    .rsp_data   (rsp_enc)
  );

  assign unused_req = ^{req_hdr.ftype, req_hdr.rsvd0, req_hdr.size[2:0],
                        req_hdr.rsvd1, req_hdr.addr[2:0]};

  // Payload is forwarded only in DATA before an overrun is detected
  assign fwd        = (state == ST_DATA) && !over_q;
  assign last_exp   = (cnt_q + CNT_W'(1)) == exp_q;
  assign hs         = treq_tvalid && treq_tready;
  assign rsp_status = (!over_q && last_exp) ? STATUS_DONE : STATUS_ERROR;

  assign wr_valid = fwd && treq_tvalid;
  assign wr_addr  = fwd ? addr_q : '0;
  assign wr_data  = fwd ? treq_tdata : '0;
  assign wr_keep  = fwd ? treq_tkeep : '0;
  assign wr_first = wr_valid && (cnt_q == '0);
  assign wr_last  = wr_valid && (treq_tlast || last_exp);

  assign tresp_tlast = tresp_tvalid;
  assign tresp_tkeep = {KEEP_W{tresp_tvalid}};

  // live_q holds tready low while reset is asserted and for one cycle after
  always_comb begin
    treq_tready = 1'b0;
    case (state)
      ST_IDLE: treq_tready = live_q;
      ST_DATA: treq_tready = over_q | wr_ready;
      ST_DROP: treq_tready = 1'b1;
      default: treq_tready = 1'b0;
    endcase
  end

  // Next-state, packet bookkeeping and registered response
  always_comb begin
    state_d     = state;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    addr_d      = addr_q;
    tid_d       = tid_q;
    prio_d      = prio_q;
    crf_d       = crf_q;
    resp_d      = resp_q;
    user_d      = user_q;
    over_d      = over_q;
    rsp_valid_d = tresp_tvalid;
    rsp_data_d  = tresp_tdata;
    rsp_user_d  = tresp_tuser;
    pkt_cnt_d   = pkt_cnt;
    err_cnt_d   = err_cnt;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          if (req_legal && !treq_tlast) begin
            state_d = ST_DATA;
            tid_d   = req_hdr.tid;
            prio_d  = req_hdr.prio;
            crf_d   = req_hdr.crf;
            resp_d  = (req_hdr.ttype == TTYPE_NWRITE_R);
            user_d  = treq_tuser;
            cnt_d   = '0;
            exp_d   = CNT_W'(req_hdr.size[7:3]) + CNT_W'(1);
            addr_d  = {req_hdr.addr[ADDR_W-1:3], 3'b000};
            over_d  = 1'b0;
          end else if (treq_tlast) begin
            // single-beat bad or header-only packet ends here
            err_cnt_d = sat_inc(err_cnt);
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (!over_q) begin
            addr_d = addr_q + ADDR_W'(8);
            cnt_d  = cnt_q + CNT_W'(1);
          end
          if (treq_tlast) begin
            if (rsp_status == STATUS_DONE) pkt_cnt_d = pkt_cnt + STAT_W'(1);
            else                           err_cnt_d = sat_inc(err_cnt);
            if (resp_q) begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = rsp_enc;
              rsp_user_d  = {user_q[15:0], user_q[31:16]};
            end else begin
              state_d = ST_IDLE;
            end
          end else if (last_exp) begin
            over_d = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (hs && treq_tlast) begin
          err_cnt_d = sat_inc(err_cnt);
          state_d   = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (tresp_tready) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_user_d  = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      state        <= ST_IDLE;
      cnt_q        <= '0;
      exp_q        <= '0;
      addr_q       <= '0;
      tid_q        <= '0;
      prio_q       <= '0;
      crf_q        <= 1'b0;
      resp_q       <= 1'b0;
      user_q       <= '0;
      over_q       <= 1'b0;
      live_q       <= 1'b0;
      tresp_tvalid <= 1'b0;
      tresp_tdata  <= '0;
      tresp_tuser  <= '0;
      pkt_cnt      <= '0;
      err_cnt      <= '0;
    end else begin
      state        <= state_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      addr_q       <= addr_d;
      tid_q        <= tid_d;
      prio_q       <= prio_d;
      crf_q        <= crf_d;
      resp_q       <= resp_d;
      user_q       <= user_d;
      over_q       <= over_d;
      live_q       <= 1'b1;
      tresp_tvalid <= rsp_valid_d;
      tresp_tdata  <= rsp_data_d;
      tresp_tuser  <= rsp_user_d;
      pkt_cnt      <= pkt_cnt_d;
      err_cnt      <= err_cnt_d;
    end
  end

endmodule
